// File: rtl/chain_score_pkg.sv
// chain_score_pkg: shared constants and types for the chain_score_pipe block.
//   - CS_*_W      : default widths of the pipeline payload fields
//   - COEF_*      : common gap coefficients (0.01*W_avg) in Q0.16
//   - neg_score() : reject score, -2^(score_w-1), for a given score width
//   - stage_t     : payload carried between the pipeline stages
// The payload struct is sized by CS_POS_W/CS_COEF_W/CS_TAG_W, so any change
// of POS_W/COEF_W/TAG_W on the top module must be mirrored here.
package chain_score_pkg;

    localparam int CS_POS_W  = 32;
    localparam int CS_COEF_W = 16;
    localparam int CS_TAG_W  = 8;

    localparam logic [15:0] COEF_15 = 16'd9830;
    localparam logic [15:0] COEF_21 = 16'd13763;
    localparam logic [15:0] COEF_25 = 16'd16384;
    localparam logic [15:0] COEF_31 = 16'd20316;

    function automatic logic signed [63:0] neg_score(input int score_w);
        return -(64'sd1 <<< (score_w - 1));
    endfunction

    typedef struct packed {
        logic signed [CS_POS_W:0] dr;    // riX - riY
        logic signed [CS_POS_W:0] dq;    // qiX - qiY
        logic [CS_POS_W-1:0]      dd;    // |dr - dq|
        logic signed [CS_POS_W:0] a;     // min(dr, dq, W)
        logic [CS_POS_W-1:0]      w;
        logic [CS_COEF_W-1:0]     coef;
        logic                     rej;
        logic [CS_TAG_W-1:0]      tag;
    } stage_t;

endpackage

// File: rtl/chain_score_ilog2.sv
// chain_ilog2: combinational floor(log2(val)) priority encoder.
//   val        in  [WIDTH-1:0] : operand
//   log2_floor out [LOG_W-1:0] : index of the highest set bit (0 for val 0 or 1)
module chain_ilog2 #(
    parameter int WIDTH = 32,
    parameter int LOG_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] val,
    output logic [LOG_W-1:0] log2_floor
);

    // Ascending scan: the last (highest) set bit wins.
    always_comb begin
        log2_floor = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (val[i]) begin
                log2_floor = LOG_W'(i);
            end
        end
    end

endmodule

// File: rtl/chain_score_pipe.sv
// chain_score_pipe: 4-stage anchor-pair chain score with valid/ready flow.
//   score = min(dr,dq,W) - (floor(dd*coef >> FRAC_W) + (ilog2(dd) >> 1))
//   with dr = riX-riY, dq = qiX-qiY, dd = |dr-dq|; misordered pairs or
//   dr/dq > MAX_DIST give out_reject=1 and out_score = -2^(SCORE_W-1).
// Ports:
//   clk, reset (sync, active-high)
//   in_valid/in_ready, riX, riY, qiX, qiY, W, coef, in_tag : input beat
//   out_valid/out_ready, out_score, out_reject, out_tag      : result beat
// Build option: define CHAIN_SCORE_ROUND_EN to round the linear gap term
// half-up instead of flooring it. Latency and handshake are unchanged.
module chain_score_pipe
    import chain_score_pkg::*;
#(
    parameter int POS_W    = CS_POS_W,
    parameter int COEF_W   = CS_COEF_W,
    parameter int FRAC_W   = 16,
    parameter int SCORE_W  = 32,
    parameter int TAG_W    = CS_TAG_W,
    parameter int MAX_DIST = 5000
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [POS_W-1:0]          riX,
    input  logic [POS_W-1:0]          riY,
    input  logic [POS_W-1:0]          qiX,
    input  logic [POS_W-1:0]          qiY,
    input  logic [POS_W-1:0]          W,
    input  logic [COEF_W-1:0]         coef,
    input  logic [TAG_W-1:0]          in_tag,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic signed [SCORE_W-1:0] out_score,
    output logic                      out_reject,
    output logic [TAG_W-1:0]          out_tag
);

    localparam int LOG_W  = $clog2(POS_W);
    // One spare bit so the rounding offset can never overflow the product.
    localparam int PROD_W = POS_W + COEF_W + 1;
    localparam int LIN_W  = PROD_W - FRAC_W;
    // Wide enough for A - B with any operands, so saturation sees true values.
    localparam int DIFF_W = PROD_W + 2;

    localparam logic signed [SCORE_W-1:0] NEG_SCORE = SCORE_W'(neg_score(SCORE_W));
    localparam logic signed [DIFF_W-1:0]  SAT_HI    = DIFF_W'((64'sd1 <<< (SCORE_W - 1)) - 64'sd1);
    localparam logic signed [DIFF_W-1:0]  SAT_LO    = DIFF_W'(neg_score(SCORE_W));
    localparam logic signed [POS_W:0]     MAX_D     = (POS_W + 1)'(MAX_DIST);

    logic advance;

    stage_t s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
    logic   s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d, s3_valid_q, s3_valid_d;

    logic [LIN_W-1:0] s3_lin_q, s3_lin_d;
    logic [LOG_W-1:0] s3_lg_q, s3_lg_d;

    logic                      out_valid_q, out_valid_d;
    logic signed [SCORE_W-1:0] out_score_q, out_score_d;
    logic                      out_reject_q, out_reject_d;
    logic [TAG_W-1:0]          out_tag_q, out_tag_d;

    logic signed [POS_W+1:0] diff_dr_dq;
    logic signed [POS_W:0]   a_min;
    logic [PROD_W-1:0]       prod;
    logic [LOG_W-1:0]        dd_log2;
    logic signed [DIFF_W-1:0] b_term, score_wide;

    // The whole pipeline moves together; a stalled output freezes every stage.
    assign advance  = !out_valid_q || out_ready;
    assign in_ready = advance;

    chain_ilog2 #(.WIDTH(POS_W), .LOG_W(LOG_W)) u_ilog2 (
        .val        (s2_q.dd),
        .log2_floor (dd_log2)
    );

    always_comb begin
        s1_d = s1_q;  s1_valid_d = s1_valid_q;
        s2_d = s2_q;  s2_valid_d = s2_valid_q;
        s3_d = s3_q;  s3_valid_d = s3_valid_q;
        s3_lin_d = s3_lin_q;
        s3_lg_d  = s3_lg_q;
        out_valid_d  = out_valid_q;
        out_score_d  = out_score_q;
        out_reject_d = out_reject_q;
        out_tag_d    = out_tag_q;

        // S2 datapath
        diff_dr_dq = {s1_q.dr[POS_W], s1_q.dr} - {s1_q.dq[POS_W], s1_q.dq};
        a_min = ($signed(s1_q.dr) < $signed(s1_q.dq)) ? s1_q.dr : s1_q.dq;
        if ($signed({1'b0, s1_q.w}) < a_min) begin
            a_min = {1'b0, s1_q.w};
        end

        // S3 datapath
        prod = PROD_W'(s2_q.dd) * PROD_W'(s2_q.coef);
`ifdef CHAIN_SCORE_ROUND_EN
        prod = prod + (PROD_W'(1) << (FRAC_W - 1));
`endif

        // S4 datapath; a zero diagonal gap carries no penalty at all.
        b_term = (s3_q.dd == '0) ? '0
               : $signed(DIFF_W'(s3_lin_q)) + $signed(DIFF_W'(s3_lg_q));
        score_wide = {{(DIFF_W - POS_W - 1){s3_q.a[POS_W]}}, s3_q.a} - b_term;

        if (advance) begin
            s1_valid_d = in_valid;
            s1_d.dr    = $signed({1'b0, riX}) - $signed({1'b0, riY});
            s1_d.dq    = $signed({1'b0, qiX}) - $signed({1'b0, qiY});
            s1_d.dd    = '0;
            s1_d.a     = '0;
            s1_d.w     = W;
            s1_d.coef  = coef;
            s1_d.rej   = (riX <= riY) || (qiX <= qiY);
            s1_d.tag   = in_tag;

            s2_valid_d = s1_valid_q;
            s2_d       = s1_q;
            s2_d.rej   = s1_q.rej || ($signed(s1_q.dr) > MAX_D) || ($signed(s1_q.dq) > MAX_D);
            // Only rejected pairs can exceed POS_W bits here, and their
            // score is overridden, so the truncation is harmless.
            s2_d.dd    = (diff_dr_dq < 0) ? POS_W'(-diff_dr_dq) : POS_W'(diff_dr_dq);
            s2_d.a     = a_min;

            s3_valid_d = s2_valid_q;
            s3_d       = s2_q;
            s3_lin_d   = LIN_W'(prod >> FRAC_W);
            s3_lg_d    = dd_log2 >> 1;

            out_valid_d = s3_valid_q;
            if (s3_valid_q) begin
                out_reject_d = s3_q.rej;
                out_tag_d    = s3_q.tag;
                if (s3_q.rej) begin
                    out_score_d = NEG_SCORE;
                end else if (score_wide > SAT_HI) begin
                    out_score_d = SAT_HI[SCORE_W-1:0];
                end else if (score_wide < SAT_LO) begin
                    out_score_d = NEG_SCORE;
                end else begin
                    out_score_d = score_wide[SCORE_W-1:0];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q <= '0;  s1_valid_q <= 1'b0;
            s2_q <= '0;  s2_valid_q <= 1'b0;
            s3_q <= '0;  s3_valid_q <= 1'b0;
            s3_lin_q     <= '0;
            s3_lg_q      <= '0;
            out_valid_q  <= 1'b0;
            out_score_q  <= '0;
            out_reject_q <= 1'b0;
            out_tag_q    <= '0;
        end else begin
            s1_q <= s1_d;  s1_valid_q <= s1_valid_d;
            s2_q <= s2_d;  s2_valid_q <= s2_valid_d;
            s3_q <= s3_d;  s3_valid_q <= s3_valid_d;
            s3_lin_q     <= s3_lin_d;
            s3_lg_q      <= s3_lg_d;
            out_valid_q  <= out_valid_d;
            out_score_q  <= out_score_d;
            out_reject_q <= out_reject_d;
            out_tag_q    <= out_tag_d;
        end
    end

    // The last stage only needs a, dd, rej and tag from the payload.
    logic s3_unused_bits;
    assign s3_unused_bits = ^{s3_q.dr, s3_q.dq, s3_q.w, s3_q.coef};

    assign out_valid  = out_valid_q;
    assign out_score  = out_score_q;
    assign out_reject = out_reject_q;
    assign out_tag    = out_tag_q;

endmodule

// File: tb/tb_chain_score_pipe.sv
// Directed bench for chain_score_pipe: single-beat score/reject vectors with
// latency checks, an 8-beat backpressure run, and a mid-stream reset.
module tb_chain_score_pipe;
    import chain_score_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] riX = '0, riY = '0, qiX = '0, qiY = '0, W = '0;
    logic [15:0] coef = '0;
    logic [7:0]  in_tag = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic signed [31:0] out_score;
    logic        out_reject;
    logic [7:0]  out_tag;

    int n_vec = 0;
    int n_err = 0;

    localparam logic signed [63:0] NEG = -64'sd2147483648;

    chain_score_pipe dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .riX        (riX),
        .riY        (riY),
        .qiX        (qiX),
        .qiY        (qiY),
        .W          (W),
        .coef       (coef),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_score  (out_score),
        .out_reject (out_reject),
        .out_tag    (out_tag)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [63:0] obs,
                         input logic signed [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [31:0] rix, riy, qix, qiy, w,
                         input logic [15:0] cf, input logic [7:0] tg);
        riX = rix; riY = riy; qiX = qix; qiY = qiy; W = w; coef = cf; in_tag = tg;
    endtask

    // One beat with out_ready high: out_valid must rise on the 4th edge
    // counting the acceptance edge, then the result fields are compared.
    task automatic run_beat(input string name, input logic [31:0] rix, riy, qix, qiy, w,
                            input logic [15:0] cf, input logic [7:0] tg,
                            input logic signed [63:0] exp_score, input logic exp_rej);
        @(negedge clk);
        drive(rix, riy, qix, qiy, w, cf, tg);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1;
        check({name, " in_ready"}, 64'(in_ready), 1);
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk);
            @(negedge clk);
            in_valid = 1'b0;
            check($sformatf("%s out_valid@edge%0d", name, k), 64'(out_valid), (k == 4) ? 1 : 0);
        end
        check({name, " score"},  64'($signed(out_score)), exp_score);
        check({name, " reject"}, 64'(out_reject), 64'(exp_rej));
        check({name, " tag"},    64'(out_tag), 64'(tg));
        $display("beat %s tag=%0d score=%0d reject=%0b", name, out_tag, out_score, out_reject);
    endtask

    initial begin
        logic signed [63:0] exp_round, exp_c25;
        int next_beat;
        int exp_tag;

`ifdef CHAIN_SCORE_ROUND_EN
        exp_round = 82;
        exp_c25   = 85;
`else
        exp_round = 83;
        exp_c25   = 86;
`endif

        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("reset out_valid",  64'(out_valid), 0);
        check("reset out_score",  64'($signed(out_score)), 0);
        check("reset out_reject", 64'(out_reject), 0);
        check("reset out_tag",    64'(out_tag), 0);
        check("reset in_ready",   64'(in_ready), 1);

        run_beat("lin_log",   1000,  900, 1050,  940,    50, COEF_15, 8'd1,  48, 1'b0);
        run_beat("zero_diag",  120,  100,  220,  200,    50, COEF_15, 8'd2,  20, 1'b0);
        run_beat("round",     1200, 1000,  600,  500,   500, COEF_15, 8'd3,  exp_round, 1'b0);
        run_beat("coef25",    1100, 1000, 1150, 1000,  1000, COEF_25, 8'd4,  exp_c25, 1'b0);
        run_beat("w0_coef0",  1100, 1000, 1150, 1000,     0, 16'd0,   8'd5,  -2, 1'b0);
        run_beat("dd_one",    1100, 1000, 1101, 1000,   200, COEF_15, 8'd6,  100, 1'b0);
        run_beat("max_dist",  6000, 1000, 6000, 1000, 10000, COEF_15, 8'd7,  5000, 1'b0);
        run_beat("rej_order",  900, 1000, 1050,  940,    50, COEF_15, 8'd8,  NEG, 1'b1);
        run_beat("rej_equal",  200,  100,  100,  100,    50, COEF_15, 8'd9,  NEG, 1'b1);
        run_beat("rej_far",   7000, 1000, 7000, 1000,    50, COEF_15, 8'd10, NEG, 1'b1);
        run_beat("rej_5001",  6001, 1000, 1100, 1000,    50, COEF_15, 8'd11, NEG, 1'b1);

        // Backpressure: beats 0..7 back to back, out_ready low in cycles 5-7.
        // Beats 0-3 go in on edges 1-4, beats 4-7 on edges 8-11; results show
        // tag 0 through cycle 8, then tag c-8 up to cycle 15. Score = 10+tag.
        next_beat = 0;
        for (int c = 1; c <= 17; c++) begin
            @(negedge clk);
            out_ready = !(c >= 5 && c <= 7);
            if (next_beat < 8) begin
                drive(1100, 1000, 1100, 1000, 32'(10 + next_beat), COEF_15, 8'(next_beat));
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            check($sformatf("bp c%0d in_ready", c), 64'(in_ready), (c >= 5 && c <= 7) ? 0 : 1);
            check($sformatf("bp c%0d out_valid", c), 64'(out_valid), (c >= 5 && c <= 15) ? 1 : 0);
            if (c >= 5 && c <= 15) begin
                exp_tag = (c <= 8) ? 0 : c - 8;
                check($sformatf("bp c%0d out_tag", c), 64'(out_tag), 64'(exp_tag));
                check($sformatf("bp c%0d out_score", c), 64'($signed(out_score)), 64'(10 + exp_tag));
                $display("bp cycle %0d tag=%0d score=%0d ready=%0b", c, out_tag, out_score, out_ready);
            end
            @(posedge clk);
            if (next_beat < 8 && !(c >= 5 && c <= 7)) next_beat++;
        end

        // Mid-stream reset with three beats in flight.
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            drive(1100, 1000, 1100, 1000, 50, COEF_15, 8'(8'hA0 + k));
            in_valid = 1'b1;
            @(posedge clk);
        end
        @(negedge clk);
        in_valid = 1'b0;
        reset    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("midreset out_valid", 64'(out_valid), 0);
        check("midreset in_ready",  64'(in_ready), 1);
        check("midreset out_tag",   64'(out_tag), 0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check($sformatf("post-reset idle%0d out_valid", k), 64'(out_valid), 0);
        end
        $display("mid-stream reset applied, pipeline flushed");
        run_beat("after_reset", 1000, 900, 1050, 940, 50, COEF_15, 8'h5A, 48, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
